ahbsram_mem_init_arb: RTL
=========================

// Module: ahbsram_mem_init_arb
// PURPOSE
//  Memory-side stage directly downstream of the AHB-Lite SRAM interface. Consumes its
//  40-bit write/read/address/byte-enable requests, drives the LSRAM array and returns
//  40-bit read data. After reset, or on request, zero-fills the array word by word.
//  Drives BUSY back to the interface while the fill runs.
// PARAMETERS
//  MEM_AWIDTH  19     request/array address width (word address)
//  MEM_DEPTH   4096   implemented words; addresses >= MEM_DEPTH are out of range
//  INIT_BYTE   8'h00  fill value per byte lane; lane = {2'b00,INIT_BYTE}
// PORTS
//  HCLK            in   1           clock, all logic rising-edge
//  aresetn         in   1           asynchronous, active-low reset
//  ahbsram_write   in   1           write strobe from interface
//  ahbsram_read    in   1           read strobe from interface
//  ahbsram_wdata   in   40          4 lanes x 10b; lane = {2 spare, byte}
//  ahbsram_addr    in   MEM_AWIDTH  word address
//  ahbsram_byteen  in   4           byte-lane write enables
//  ahbsram_rdata   out  40          read data to interface
//  BUSY            out  1           fill in progress, requests not accepted
//  init_req        in   1           single-cycle pulse: start re-fill
//  init_done       out  1           one-cycle pulse when fill completes
//  req_dropped     out  1           sticky: request seen while BUSY
//  oor_err         out  1           sticky: request address >= MEM_DEPTH
//  err_clr         in   1           clears req_dropped, oor_err (and par_err)
//  mem_addr        out  MEM_AWIDTH  array address
//  mem_wdata       out  40          array write data
//  mem_we          out  4           array per-lane write enables
//  mem_re          out  1           array read enable; data valid 1 cycle later
//  mem_rdata       in   40          array read data
// BEHAVIOUR
//  - Reset: state INIT, fill counter = 0, BUSY=1, init_done=0, req_dropped=0,
//    oor_err=0, ahbsram_rdata=0, rd_pend=0, hold reg=0.
//  - Reset mid-fill restarts the fill from word 0.
//  - States INIT, RUN. Fill counter width $clog2(MEM_DEPTH).
//  - INIT: each cycle mem_addr=cnt, mem_we=4'hF, mem_wdata={4{2'b00,INIT_BYTE}},
//    mem_re=0, BUSY=1. cnt increments by 1. On cnt==MEM_DEPTH-1 the word is written
//    and state -> RUN next cycle, with init_done=1 for that cycle and BUSY=0.
//    Fill takes exactly MEM_DEPTH cycles.
//  - INIT: ahbsram_write/read ignored (no array access); sets req_dropped.
//    init_req ignored.
//  - RUN: combinational pass-through: mem_addr=ahbsram_addr, mem_wdata=ahbsram_wdata,
//    mem_we=ahbsram_byteen & {4{ahbsram_write}}, mem_re=ahbsram_read.
//  - Write and read asserted together in RUN: write wins, read dropped, req_dropped set.
//  - Out-of-range in RUN (addr >= MEM_DEPTH): mem_we=0, mem_re=0, oor_err set.
//    An out-of-range read still sets rd_pend and returns 40'h0.
//  - Read return: rd_pend <= accepted read. While rd_pend=1,
//    ahbsram_rdata=mem_rdata and the hold reg captures it.
//    Otherwise ahbsram_rdata = hold reg.
//    Read-to-data latency is 1 cycle, matching the interface's registered read enable.
//  - init_req in RUN: a write or read in the same cycle completes normally.
//    State -> INIT next cycle with cnt=0; a pending read returns during the first INIT cycle.
//  - err_clr with a same-cycle set event: set wins.
// CONFIGURATION
//  AHBSRAM_PARITY_EN defined:
//    - Writes: lane bit 8 = ^byte (even parity), bit 9 = 0, regardless of wdata[9:8].
//    - Fill words carry correct parity.
//    - On read return, any lane with bit8 != ^byte[7:0] sets sticky par_err (out, 1b);
//      err_clr clears it.
//  Not defined:
//    - Spare bits pass through unchanged.
//    - par_err port is absent.
// TESTING
//  T1 reset, MEM_DEPTH=16 -> BUSY=1 for 16 cycles, mem_we=4'hF on addr 0..15,
//     init_done pulses once, then BUSY=0.
//  T2 RUN: write addr 5, byteen 4'b0010, wdata lane1=0x0AB; read addr 5 ->
//     next cycle rdata=0x000_000_0AB_000.
//  T3 read addr 20 with MEM_DEPTH=16 -> mem_re=0, oor_err=1, rdata 40'h0;
//     err_clr -> oor_err=0.
//  T4 write during INIT -> no mem_we to addr, req_dropped=1, fill count unaffected.
//  T5 init_req with same-cycle read addr 3 -> read data returned,
//     then full re-fill, addr 3 reads 0.
//  T6 PARITY_EN: force mem_rdata lane0 bit8 flipped -> par_err=1 next cycle.

Source files
------------

// File: rtl/ahbsram_mem_init_arb.sv
// rtl/ahbsram_mem_init_arb.sv - memory-side request stage with zero-fill after reset or on init_req
// Optional feature macro: AHBSRAM_PARITY_EN (per-lane even parity on writes/fill, sticky par_err on reads).
module ahbsram_mem_init_arb #(
  parameter int          MEM_AWIDTH = 19,
  parameter int          MEM_DEPTH  = 4096,
  parameter logic [7:0]  INIT_BYTE  = 8'h00
) (
  input  logic                  HCLK,
  input  logic                  aresetn,
  input  logic                  ahbsram_write,
  input  logic                  ahbsram_read,
  input  logic [39:0]           ahbsram_wdata,
  input  logic [MEM_AWIDTH-1:0] ahbsram_addr,
  input  logic [3:0]            ahbsram_byteen,
  output logic [39:0]           ahbsram_rdata,
  output logic                  BUSY,
  input  logic                  init_req,
  output logic                  init_done,
  output logic                  req_dropped,
  output logic                  oor_err,
`ifdef AHBSRAM_PARITY_EN
  output logic                  par_err,
`endif
  input  logic                  err_clr,
  output logic [MEM_AWIDTH-1:0] mem_addr,
  output logic [39:0]           mem_wdata,
  output logic [3:0]            mem_we,
  output logic                  mem_re,
  input  logic [39:0]           mem_rdata
);
  localparam int                  CW        = $clog2(MEM_DEPTH);
  localparam logic [CW-1:0]       LAST      = CW'(MEM_DEPTH - 1);
  localparam logic [MEM_AWIDTH:0] DEPTH_EXT = (MEM_AWIDTH + 1)'(MEM_DEPTH);

  typedef enum logic {INIT, RUN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic            rd_pend_q, rd_zero_q;
  logic [39:0]     hold_q;
  logic            in_range, fill_last, rd_acc, drop_set, oor_set;
  logic [39:0]     fill_word, wr_word, rd_word;

  // Lane = {spare, parity-or-spare, byte}; with parity enabled the spare bits are regenerated.
  function automatic logic [39:0] lane_fix(input logic [39:0] d);
    lane_fix = d;
`ifdef AHBSRAM_PARITY_EN
    for (int l = 0; l < 4; l++)
      lane_fix[l*10 +: 10] = {1'b0, ^d[l*10 +: 8], d[l*10 +: 8]};
`endif
  endfunction

  assign fill_word     = lane_fix({4{2'b00, INIT_BYTE}});
  assign wr_word       = lane_fix(ahbsram_wdata);
  assign in_range      = {1'b0, ahbsram_addr} < DEPTH_EXT;
  assign fill_last     = (cnt_q == LAST);
  assign rd_word       = rd_zero_q ? 40'h0 : mem_rdata;
  assign ahbsram_rdata = rd_pend_q ? rd_word : hold_q;

  always_ff @(posedge HCLK or negedge aresetn) begin
    if (!aresetn) state_q <= INIT;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    BUSY      = 1'b0;
    mem_addr  = ahbsram_addr;
    mem_wdata = wr_word;
    mem_we    = 4'h0;
    mem_re    = 1'b0;
    rd_acc    = 1'b0;
    drop_set  = 1'b0;
    oor_set   = 1'b0;
    case (state_q)
      INIT: begin
        BUSY      = 1'b1;
        mem_addr  = MEM_AWIDTH'(cnt_q);
        mem_wdata = fill_word;
        mem_we    = 4'hF;
        drop_set  = ahbsram_write | ahbsram_read;
        if (fill_last) state_d = RUN;
      end
      default: begin
        // Write has priority; a colliding read is dropped and flagged.
        rd_acc   = ahbsram_read & ~ahbsram_write;
        drop_set = ahbsram_write & ahbsram_read;
        oor_set  = (ahbsram_write | ahbsram_read) & ~in_range;
        mem_we   = ahbsram_byteen & {4{ahbsram_write & in_range}};
        mem_re   = rd_acc & in_range;
        if (init_req) state_d = INIT;
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q       <= '0;
      init_done   <= 1'b0;
      req_dropped <= 1'b0;
      oor_err     <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_zero_q   <= 1'b0;
      hold_q      <= 40'h0;
    end else begin
      cnt_q       <= (state_q == INIT && !fill_last) ? cnt_q + 1'b1 : '0;
      init_done   <= (state_q == INIT) && fill_last;
      req_dropped <= drop_set | (req_dropped & ~err_clr);
      oor_err     <= oor_set | (oor_err & ~err_clr);
      // Out-of-range reads still complete, returning zero instead of array data.
      rd_pend_q   <= rd_acc;
      rd_zero_q   <= rd_acc & ~in_range;
      if (rd_pend_q) hold_q <= rd_word;
    end
  end

`ifdef AHBSRAM_PARITY_EN
  logic par_bad;

  always_comb begin
    par_bad = 1'b0;
    for (int l = 0; l < 4; l++)
      par_bad = par_bad | (mem_rdata[l*10 + 8] != ^mem_rdata[l*10 +: 8]);
  end

  always_ff @(posedge HCLK or negedge aresetn) begin
    if (!aresetn) par_err <= 1'b0;
    else          par_err <= (rd_pend_q & ~rd_zero_q & par_bad) | (par_err & ~err_clr);
  end
`endif

endmodule
